// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register.
// Carries {valid, payload} through DEPTH slots in series, honouring the
// ctrl stall vector (hold / bubble / advance) and an exception flush.
// Optional feature macro: PIPE_STAGE_PERF_EN enables the saturating
// bubble counter. Without it bubble_cnt is tied to zero.

// One register slot of the chain. kill has priority over a load. With both
// low the slot holds its current contents.
module pipe_stage_slot #(
    parameter int DATA_W   = 110,
    parameter int ZERO_BUB = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              ld_en,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid_q,
    output logic [DATA_W-1:0] data_q,
    output logic              valid_d
);
    logic [DATA_W-1:0] data_d;

    // Next-state select: kill, then load, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill) begin
            valid_d = 1'b0;
            data_d  = (ZERO_BUB != 0) ? '0 : data_q;
        end else if (ld_en) begin
            valid_d = ld_valid;
            data_d  = ld_data;
        end
    end

    // Slot state flops, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

module pipe_stage_reg #(
    parameter int DATA_W   = 110,
    parameter int DEPTH    = 1,
    parameter int STAGE    = 4,
    parameter int STALL_W  = 6,
    parameter int ZERO_BUB = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [2:0]         occupancy,
    output logic [15:0]        bubble_cnt
);
    logic                           up_stall;
    logic                           dn_stall;
    logic                           hold;
    logic                           bubble;
    logic [DEPTH-1:0]               slot_kill;
    logic [DEPTH-1:0]               slot_ld_en;
    logic [DEPTH-1:0]               slot_ld_vld;
    logic [DEPTH-1:0][DATA_W-1:0]   slot_ld_data;
    logic [DEPTH-1:0]               slot_vld_q;
    logic [DEPTH-1:0][DATA_W-1:0]   slot_data_q;
    logic [DEPTH-1:0]               slot_vld_d;
    logic [2:0]                     occupancy_q;
    logic [2:0]                     occupancy_d;
    logic                           unused_stall;

    assign up_stall = stall[STAGE];

    // The last stage has no downstream stall bit; treat it as free.
    generate
        if (STAGE + 1 < STALL_W) begin : g_dn
            assign dn_stall = stall[STAGE+1];
        end else begin : g_no_dn
            assign dn_stall = 1'b0;
        end
    endgenerate

    // Only one or two stall bits matter here; the rest are deliberately ignored.
    assign unused_stall = ^stall;

    // Mode decode: flush beats every stall combination.
    always_comb begin
        hold   = 1'b0;
        bubble = 1'b0;
        if (!flush && up_stall) begin
            hold   = dn_stall;
            bubble = !dn_stall;
        end
    end

    // Per-slot control: slot 0 takes in_* (or a bubble), others shift from the previous slot.
    always_comb begin
        slot_kill    = '0;
        slot_ld_en   = '0;
        slot_ld_vld  = '0;
        slot_ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_kill[i]  = flush || (bubble && (i == 0));
            slot_ld_en[i] = !hold;
            if (i == 0) begin
                slot_ld_vld[i]  = in_valid;
                slot_ld_data[i] = in_data;
            end else begin
                slot_ld_vld[i]  = slot_vld_q[i-1];
                slot_ld_data[i] = slot_data_q[i-1];
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_slot
            pipe_stage_slot #(
                .DATA_W   (DATA_W),
                .ZERO_BUB (ZERO_BUB)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .kill     (slot_kill[g]),
                .ld_en    (slot_ld_en[g]),
                .ld_valid (slot_ld_vld[g]),
                .ld_data  (slot_ld_data[g]),
                .valid_q  (slot_vld_q[g]),
                .data_q   (slot_data_q[g]),
                .valid_d  (slot_vld_d[g])
            );
        end
    endgenerate

    // Occupancy is counted from the next-state valids so it tracks the slots exactly.
    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + 3'(slot_vld_d[i]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) occupancy_q <= '0;
        else     occupancy_q <= occupancy_d;
    end

    assign occupancy = occupancy_q;
    assign out_valid = slot_vld_q[DEPTH-1];
    assign out_data  = slot_data_q[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;

    // Saturating count of bubble edges; flush edges never count.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bubble_cnt_q <= '0;
        else     bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (DEPTH 1/2/3 with zeroing
// bubbles, DEPTH 1 with kept payload) share one stimulus stream.
module tb_pipe_stage_reg;
    localparam int DW = 32;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    stall = 6'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          ov1, ov2, ov3, ovz;
    logic [DW-1:0] od1, od2, od3, odz;
    logic [2:0]    oc1, oc2, oc3, ocz;
    logic [15:0]   bc1, bc2, bc3, bcz;

    int errors = 0;
    int checks = 0;
    int bub_exp = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .STAGE(4), .STALL_W(6), .ZERO_BUB(1)) u_d1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov1), .out_data(od1), .occupancy(oc1), .bubble_cnt(bc1));
    pipe_stage_reg #(.DATA_W(DW), .DEPTH(2), .STAGE(4), .STALL_W(6), .ZERO_BUB(1)) u_d2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov2), .out_data(od2), .occupancy(oc2), .bubble_cnt(bc2));
    pipe_stage_reg #(.DATA_W(DW), .DEPTH(3), .STAGE(4), .STALL_W(6), .ZERO_BUB(1)) u_d3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov3), .out_data(od3), .occupancy(oc3), .bubble_cnt(bc3));
    pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .STAGE(4), .STALL_W(6), .ZERO_BUB(0)) u_zb (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ovz), .out_data(odz), .occupancy(ocz), .bubble_cnt(bcz));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ov3); end
        checks++; if (od3 !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", od3); end
        checks++; if (oc3 !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", oc3); end
        checks++; if (bc1 !== 16'h0) begin errors++; $display("FAIL reset_bcnt got=%0d exp=0", bc1); end
        step();
        rst = 1'b0;
        bub_exp = 0;
    endtask

    task automatic test_latency();
        stall = 6'b0; in_valid = 1'b1;
        in_data = 32'hA; step();
        checks++; if (od1 !== 32'hA || ov1 !== 1'b1) begin errors++; $display("FAIL lat_d1 got=%b/%h exp=1/a", ov1, od1); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL lat_d3_early got=%b exp=0", ov3); end
        in_data = 32'hB; step();
        in_data = 32'hC; step();
        checks++; if (ov3 !== 1'b1 || od3 !== 32'hA) begin errors++; $display("FAIL lat_e3 got=%b/%h exp=1/a", ov3, od3); end
        checks++; if (oc3 !== 3'd3) begin errors++; $display("FAIL lat_occ3 got=%0d exp=3", oc3); end
        in_valid = 1'b0; in_data = 32'hD; step();
        checks++; if (ov3 !== 1'b1 || od3 !== 32'hB || oc3 !== 3'd2) begin
            errors++; $display("FAIL lat_e4 got=%b/%h/%0d exp=1/b/2", ov3, od3, oc3); end
        in_data = 32'hE; step();
        checks++; if (ov3 !== 1'b1 || od3 !== 32'hC || oc3 !== 3'd1) begin
            errors++; $display("FAIL lat_e5 got=%b/%h/%0d exp=1/c/1", ov3, od3, oc3); end
    endtask

    task automatic test_bubble();
        stall = 6'b0; in_valid = 1'b1; in_data = 32'h1234; step();
        checks++; if (ovz !== 1'b1 || odz !== 32'h1234) begin errors++; $display("FAIL bub_load got=%b/%h exp=1/1234", ovz, odz); end
        stall = 6'b011111; in_data = 32'h5555;
        step(); bub_exp++;
        step(); bub_exp++;
        checks++; if (ov1 !== 1'b0 || od1 !== 32'h0) begin errors++; $display("FAIL bub_zero got=%b/%h exp=0/0", ov1, od1); end
        checks++; if (oc1 !== 3'd0) begin errors++; $display("FAIL bub_occ got=%0d exp=0", oc1); end
        checks++; if (ovz !== 1'b0 || odz !== 32'h1234) begin errors++; $display("FAIL bub_keep got=%b/%h exp=0/1234", ovz, odz); end
        checks++; if (bc1 !== (PERF ? 16'(bub_exp) : 16'h0)) begin
            errors++; $display("FAIL bub_cnt got=%0d exp=%0d", bc1, PERF ? bub_exp : 0); end
        stall = 6'b0;
    endtask

    task automatic test_hold();
        stall = 6'b0; in_valid = 1'b1;
        in_data = 32'h11; step();
        in_data = 32'h22; step();
        checks++; if (ov2 !== 1'b1 || od2 !== 32'h11 || oc2 !== 3'd2) begin
            errors++; $display("FAIL hold_fill got=%b/%h/%0d exp=1/11/2", ov2, od2, oc2); end
        stall = 6'b111111;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h90 + k; in_valid = k[0];
            step();
            checks++; if (od2 !== 32'h11 || oc2 !== 3'd2 || ov2 !== 1'b1) begin
                errors++; $display("FAIL hold_%0d got=%b/%h/%0d exp=1/11/2", k, ov2, od2, oc2); end
        end
        stall = 6'b0; in_valid = 1'b1; in_data = 32'h33; step();
        checks++; if (od2 !== 32'h22 || oc2 !== 3'd2) begin errors++; $display("FAIL hold_rel1 got=%h/%0d exp=22/2", od2, oc2); end
        in_valid = 1'b0; in_data = 32'h44; step();
        checks++; if (od2 !== 32'h33 || ov2 !== 1'b1 || oc2 !== 3'd1) begin
            errors++; $display("FAIL hold_rel2 got=%b/%h/%0d exp=1/33/1", ov2, od2, oc2); end
    endtask

    task automatic test_flush();
        stall = 6'b0; in_valid = 1'b1;
        in_data = 32'h71; step();
        in_data = 32'h72; step();
        in_data = 32'h73; step();
        checks++; if (oc3 !== 3'd3) begin errors++; $display("FAIL fl_full got=%0d exp=3", oc3); end
        flush = 1'b1; stall = 6'b111111; in_data = 32'h74; step();
        checks++; if (ov3 !== 1'b0 || od3 !== 32'h0 || oc3 !== 3'd0) begin
            errors++; $display("FAIL fl_d3 got=%b/%h/%0d exp=0/0/0", ov3, od3, oc3); end
        checks++; if (ovz !== 1'b0 || odz !== 32'h73) begin errors++; $display("FAIL fl_keep got=%b/%h exp=0/73", ovz, odz); end
        checks++; if (bc3 !== (PERF ? 16'(bub_exp) : 16'h0)) begin
            errors++; $display("FAIL fl_bcnt got=%0d exp=%0d", bc3, PERF ? bub_exp : 0); end
        // flush while in a bubble pattern must not count either
        stall = 6'b011111; step();
        checks++; if (bc1 !== (PERF ? 16'(bub_exp) : 16'h0)) begin
            errors++; $display("FAIL fl_bub_bcnt got=%0d exp=%0d", bc1, PERF ? bub_exp : 0); end
        flush = 1'b0; stall = 6'b0;
    endtask

    task automatic test_async_reset();
        stall = 6'b0; in_valid = 1'b1;
        in_data = 32'hC1; step();
        in_data = 32'hC2; step();
        in_data = 32'hC3; step();
        #2 rst = 1'b1;
        #1;
        checks++; if (ov3 !== 1'b0 || od3 !== 32'h0 || oc3 !== 3'd0) begin
            errors++; $display("FAIL arst got=%b/%h/%0d exp=0/0/0", ov3, od3, oc3); end
        checks++; if (bc1 !== 16'h0 || ov1 !== 1'b0) begin errors++; $display("FAIL arst_d1 got=%b/%0d exp=0/0", ov1, bc1); end
        bub_exp = 0;
        #1 rst = 1'b0;
        in_data = 32'hC4; step();
        checks++; if (ov1 !== 1'b1 || od1 !== 32'hC4 || ov3 !== 1'b0 || oc3 !== 3'd1) begin
            errors++; $display("FAIL arst_cap got=%b/%h/%b/%0d exp=1/c4/0/1", ov1, od1, ov3, oc3); end
    endtask

    initial begin
        #2;
        test_reset();
        test_latency();
        test_bubble();
        test_hold();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
